// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM with byte-lane write enables, 1- or 2-cycle read latency,
// selectable same-address read-during-write policy and an optional post-reset clear.
module sdp_ram_be #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 10,
  parameter int BYTE_W         = 8,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/BYTE_W-1:0] wr_be,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     init_busy
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 2 ** ADDR_W;

  if ((DATA_W % BYTE_W) != 0) begin : g_bad_byte_w
    $error("sdp_ram_be: DATA_W must be a multiple of BYTE_W");
  end
  if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
    $error("sdp_ram_be: RD_LATENCY must be 1 or 2");
  end

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? S_INIT : S_RUN;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NB-1:0]       mem_wmask;

  logic                run;
  logic                rd_fire;
  logic [DATA_W-1:0]   rd_old;
  logic [DATA_W-1:0]   rd_merged;
  logic [DATA_W-1:0]   rd_word;

  // ---------------- clear sequencer FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == S_INIT) begin
      clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      if (clr_cnt_q == {ADDR_W{1'b1}}) begin
        state_d = S_RUN;
      end
    end
  end

  assign run       = (state_q == S_RUN);
  assign init_busy = (state_q == S_INIT);

  // ---------------- write port: clear sequencer owns it during INIT ----------------
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    mem_wmask = wr_be;
    if (state_q == S_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
      mem_wmask = '1;
    end else if (wr_en) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_wmask[i]) begin
          mem[mem_waddr][i*BYTE_W +: BYTE_W] <= mem_wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // ---------------- read port ----------------
  assign rd_fire = rd_en && run;
  assign rd_old  = mem[rd_addr];

  // Write-first view of the addressed word: lanes being written this edge come from wr_data.
  always_comb begin
    rd_merged = rd_old;
    for (int i = 0; i < NB; i++) begin
      if (run && wr_en && wr_be[i] && (wr_addr == rd_addr)) begin
        rd_merged[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign rd_word = (RDW_MODE != 0) ? rd_merged : rd_old;

  // rd_valid pulses for one cycle per result; rd_data is only loaded with a result,
  // so it holds the last result while no read is due. There is no back-pressure.
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_fire;
      if (rd_fire) begin
        s1_data_q <= rd_word;
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic              s2_valid_q;
    logic [DATA_W-1:0] s2_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign rd_valid = s2_valid_q;
    assign rd_data  = s2_data_q;
  end else begin : g_lat1
    assign rd_valid = s1_valid_q;
    assign rd_data  = s1_data_q;
  end

endmodule

// File: tb/tb_sdp_ram_be.sv
// Bench for sdp_ram_be: two instances (latency 1 / old-data, latency 2 / write-first)
// share one random+directed stimulus and are checked every cycle against a word-level model.
module tb_sdp_ram_be;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int NB    = 2;
  localparam int DEPTH = 1024;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_be;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b;
  logic          init_busy_a, init_busy_b;

  sdp_ram_be #(
    .DATA_W(DW), .ADDR_W(AW), .BYTE_W(8),
    .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .init_busy(init_busy_a)
  );

  sdp_ram_be #(
    .DATA_W(DW), .ADDR_W(AW), .BYTE_W(8),
    .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .init_busy(init_busy_b)
  );

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] ref_mem [DEPTH];
  int            init_left;
  int            cyc;
  logic [DW-1:0] exp_q_a[$];
  logic [DW-1:0] exp_q_b[$];
  int            due_q_a[$];
  int            due_q_b[$];
  logic [DW-1:0] last_a, last_b;
  int            n_checks;
  int            n_fail;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Applies one clock edge's worth of behaviour to the model, using the inputs present at the edge.
  task automatic model_edge();
    logic [DW-1:0] old_w;
    logic [DW-1:0] new_w;
    cyc++;
    if (init_left > 0) begin
      ref_mem[DEPTH - init_left] = '0;
      init_left--;
    end else begin
      if (rd_en) begin
        old_w = ref_mem[rd_addr];
        new_w = old_w;
        if (wr_en && (wr_addr == rd_addr)) begin
          for (int l = 0; l < NB; l++) begin
            if (wr_be[l]) new_w[l*8 +: 8] = wr_data[l*8 +: 8];
          end
        end
        exp_q_a.push_back(old_w);
        due_q_a.push_back(cyc);
        exp_q_b.push_back(new_w);
        due_q_b.push_back(cyc + 1);
      end
      if (wr_en) begin
        for (int l = 0; l < NB; l++) begin
          if (wr_be[l]) ref_mem[wr_addr][l*8 +: 8] = wr_data[l*8 +: 8];
        end
      end
    end
  endtask

  task automatic check_outputs();
    if (due_q_a.size() > 0 && due_q_a[0] == cyc) begin
      last_a = exp_q_a.pop_front();
      void'(due_q_a.pop_front());
      check_eq("valid_a", 16'(rd_valid_a), 16'h1);
    end else begin
      check_eq("valid_a", 16'(rd_valid_a), 16'h0);
    end
    check_eq("data_a", rd_data_a, last_a);

    if (due_q_b.size() > 0 && due_q_b[0] == cyc) begin
      last_b = exp_q_b.pop_front();
      void'(due_q_b.pop_front());
      check_eq("valid_b", 16'(rd_valid_b), 16'h1);
    end else begin
      check_eq("valid_b", 16'(rd_valid_b), 16'h0);
    end
    check_eq("data_b", rd_data_b, last_b);

    check_eq("busy_a", 16'(init_busy_a), 16'((init_left > 0) ? 1 : 0));
    check_eq("busy_b", 16'(init_busy_b), 16'((init_left > 0) ? 1 : 0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_idle();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = AW'($urandom_range(0, DEPTH - 1));
    rd_addr = AW'($urandom_range(0, DEPTH - 1));
    wr_data = DW'($urandom);
    wr_be   = NB'($urandom_range(0, 3));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    init_left = DEPTH;
    exp_q_a.delete();
    exp_q_b.delete();
    due_q_a.delete();
    due_q_b.delete();
    last_a = '0;
    last_b = '0;
    check_eq("rst_valid_a", 16'(rd_valid_a), 16'h0);
    check_eq("rst_valid_b", 16'(rd_valid_b), 16'h0);
    check_eq("rst_data_a", rd_data_a, 16'h0);
    check_eq("rst_data_b", rd_data_b, 16'h0);
    check_eq("rst_busy_a", 16'(init_busy_a), 16'h1);
    check_eq("rst_busy_b", 16'(init_busy_b), 16'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    set_idle();
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    set_idle();
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    set_idle();
    rd_en = 1'b1; rd_addr = a;
    step();
    set_idle();
  endtask

  task automatic idle_steps(input int n);
    set_idle();
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    init_left = DEPTH;
    last_a    = '0;
    last_b    = '0;
    set_idle();
    do_reset();

    // Clear sequence with rd_en held, random writes ignored; reset aborts it at count 300.
    for (int i = 0; i < 300; i++) begin
      set_idle();
      rd_en = 1'b1;
      wr_en = 1'($urandom_range(0, 1));
      step();
    end
    do_reset();

    // Full clear after the abort; writes of 0xFFFF to 0x3FF must be ignored.
    for (int i = 0; i < DEPTH; i++) begin
      set_idle();
      rd_en = 1'b1;
      if (i % 4 == 0) begin
        wr_en = 1'b1; wr_addr = 10'h3FF; wr_data = 16'hFFFF; wr_be = 2'b11;
      end
      step();
    end

    do_read(10'h000);
    do_read(10'd511);
    do_read(10'h3FF);
    idle_steps(3);

    // Byte-enable merge
    do_write(10'h010, 16'hA5A5, 2'b11);
    do_write(10'h010, 16'h3C3C, 2'b01);
    do_read(10'h010);
    idle_steps(3);

    // Back-to-back reads at full throughput
    do_write(10'h001, 16'h1111, 2'b11);
    do_write(10'h002, 16'h2222, 2'b11);
    do_write(10'h003, 16'h3333, 2'b11);
    set_idle();
    for (int i = 1; i <= 3; i++) begin
      rd_en = 1'b1; rd_addr = AW'(i);
      step();
    end
    idle_steps(3);

    // Same-address read-during-write, then read on the next cycle
    do_write(10'h005, 16'h1234, 2'b11);
    set_idle();
    wr_en = 1'b1; wr_addr = 10'h005; wr_data = 16'hBEEF; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 10'h005;
    step();
    do_read(10'h005);
    idle_steps(3);

    // Random traffic over a small window so collisions and partial lanes are frequent
    for (int i = 0; i < 2000; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, 15));
      rd_addr = AW'($urandom_range(0, 15));
      wr_data = DW'($urandom);
      wr_be   = NB'($urandom_range(0, 3));
      step();
    end
    idle_steps(3);

    // Reset in RUN with a read in flight: no late rd_valid after release
    set_idle();
    rd_en = 1'b1; rd_addr = 10'h005;
    step();
    set_idle();
    do_reset();
    idle_steps(DEPTH + 5);
    do_read(10'h005);
    idle_steps(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #1000000;
    n_fail++;
    $display("FAIL timeout cycle=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdp_ram_be.md
Name: sdp_ram_be

Overview:
- Parametrised simple dual-port RAM: one write port, one read port, single clock.
- Next generation of the team's 16x1024 RAM. Adds per-byte write enables, selectable read latency and selectable read-during-write policy.
- Adds a read-valid strobe and an automatic post-reset memory clear sequencer.
- Used as the generic buffer/table storage for datapath blocks.

Parameters:
- DATA_W, 16, read/write data width in bits; must be a multiple of BYTE_W.
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words (default 1024).
- BYTE_W, 8, bits per byte lane; NB = DATA_W/BYTE_W lanes.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register).
- RDW_MODE, 0, same-address read-during-write policy: 0 = old data, 1 = new (write-first) data.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset release; 0 = no clear (contents undefined).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  NB  byte-lane write enables; bit i enables wr_data[i*BYTE_W +: BYTE_W].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  high for exactly one cycle when rd_data carries a new read result.
- init_busy  out  1  high while the clear sequencer runs; the user must not issue accesses while it is high.

Behaviour:
- Reset is asynchronous, active-low, on clk/rst_n as decided.
- While rst_n=0:
  - rd_data = 0, rd_valid = 0, internal read pipeline cleared.
  - init_busy = CLEAR_ON_RESET.
  - Clear counter = 0. The memory array itself is not reset.
- FSM states: INIT, RUN.
  - Reset enters INIT if CLEAR_ON_RESET=1, otherwise RUN.
- INIT state:
  - From the first clk edge with rst_n=1, writes all-zero words to address 0,1,...,DEPTH-1, one per cycle, all lanes enabled.
  - After writing DEPTH-1, moves to RUN. init_busy falls on that same edge, so it is high for exactly DEPTH cycles.
  - wr_en and rd_en are ignored in INIT: no user write, and rd_valid stays 0.
  - Reset asserted mid-INIT aborts the sequence. Release restarts it at address 0.
- Writes (RUN):
  - On an edge with wr_en=1, each lane i with wr_be[i]=1 is updated; lanes with wr_be[i]=0 keep their contents.
  - wr_en=1 with wr_be=0 is a no-op.
- Reads (RUN):
  - On an edge with rd_en=1, mem[rd_addr] is sampled.
  - RD_LATENCY=1: rd_data and rd_valid update on that same edge (data visible the cycle after the request).
  - RD_LATENCY=2: the result passes through one further register. rd_data/rd_valid appear one edge later.
  - Back-to-back reads give one result per cycle at full throughput.
  - When no read result is due, rd_valid=0 and rd_data holds its last value.
- Read-during-write, same address, same edge:
  - RDW_MODE=0: the read returns the pre-write contents.
  - RDW_MODE=1: the read returns the merged word, i.e. written lanes from wr_data and unwritten lanes from the old contents.
  - A write on edge N is always visible to a read on edge N+1 or later, in both modes.
- Different addresses on the same edge: both operations complete independently.
- Address range: all ADDR_W values are valid; there is no out-of-range case.
- Parameter checks at elaboration: a non-multiple DATA_W/BYTE_W, or RD_LATENCY not in {1,2}, must produce an elaboration error.

Test Plan:
- Clear sequence: CLEAR_ON_RESET=1, release rst_n, hold rd_en=1 throughout.
  - init_busy is high for exactly 1024 cycles and rd_valid stays 0.
  - Afterwards, reads of addresses 0, 511 and 1023 return 0x0000.
- Byte-enable merge:
  - Write 0xA5A5 to address 0x010 with wr_be=2'b11.
  - Write 0x3C3C to the same address with wr_be=2'b01.
  - Read of 0x010 returns 0xA53C.
- Latency: back-to-back reads of 0x001/0x002/0x003 holding 0x1111/0x2222/0x3333.
  - RD_LATENCY=1: rd_valid is high for 3 consecutive cycles starting 1 cycle after the first rd_en; data is 0x1111, 0x2222, 0x3333 in order.
  - RD_LATENCY=2: the same sequence, shifted one cycle later.
- Read-during-write: address 0x05 holds 0x1234; on one edge, write 0xBEEF (wr_be=2'b11) and read 0x05.
  - RDW_MODE=0: read returns 0x1234.
  - RDW_MODE=1: read returns 0xBEEF.
  - Either mode: a read on the next cycle returns 0xBEEF.
- Reset mid-operation:
  - Assert rst_n=0 at clear count 300. rd_data goes to 0 and rd_valid to 0 immediately (asynchronously).
  - After release, the clear restarts at 0 and init_busy is high for 1024 full cycles.
  - Also assert reset in RUN with a read in flight at RD_LATENCY=2: no rd_valid pulse appears after release.
- Accesses ignored during INIT: issue wr_en=1 to address 0x3FF with 0xFFFF during INIT.
  - After INIT completes, address 0x3FF reads 0x0000.
